vscale_dmem_bridge: RTL and testbench

//  Data-memory bridge directly downstream of the vscale core's dmem port.

---
 rtl/vscale_dmem_bridge.sv | 155 +++++++++++++++
 tb/tb_vscale_dmem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_bridge.sv
// vscale dmem port -> word-aligned valid/ready bus, one transaction per core access.
// Latency: load data returns at least two cycles after the address phase (one data-phase wait cycle).
// Backpressure: core stalls on dmem_wait while the bus withholds ready or response; optional abort timer.
module vscale_dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic        dmem_wait,
    output logic [31:0] dmem_rdata,
    output logic        dmem_badmem_e,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [3:0]  bus_req_wstrb,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BAD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic        first_q;
    logic [31:0] rdata_q;

    logic        complete;
    logic        accept;
    logic        misaligned;
    logic        timeout_hit;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] rdata_cmb;
    logic [31:0] wdata_src;
    logic [3:0]  wstrb_raw;

    assign complete   = (state == WAIT) && bus_resp_valid;
    assign accept     = dmem_en && ((state == IDLE) || (state == BAD) || complete);
    assign misaligned = (dmem_size[1:0] == 2'd3)
                     || ((dmem_size[1:0] == 2'd1) && dmem_addr[0])
                     || ((dmem_size[1:0] == 2'd2) && (dmem_addr[1:0] != 2'b00));

`ifdef VSCALE_DMEM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt;

    // First ISSUE cycle sees cnt=0, so the abort lands on the TIMEOUT_CYCLES-th bus cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state_nxt == ISSUE) && (state != ISSUE)) begin
            cnt <= '0;
        end else if ((state == ISSUE) || (state == WAIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout_hit = ((state == ISSUE) || ((state == WAIT) && !bus_resp_valid))
                      && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misaligned ? BAD : ISSUE;
            ISSUE: begin
                if (timeout_hit)        state_nxt = IDLE;
                else if (bus_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (complete)         state_nxt = accept ? (misaligned ? BAD : ISSUE) : IDLE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            BAD:     state_nxt = accept ? (misaligned ? BAD : ISSUE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            first_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            first_q <= accept && !misaligned;
            if (accept) begin
                addr_q <= dmem_addr;
                wen_q  <= dmem_wen;
                size_q <= dmem_size;
            end
            if (first_q) wdata_q <= dmem_wdata_delayed;
            if (complete) rdata_q <= rdata_cmb;
        end
    end

    // Store data arrives one cycle after the address, i.e. in the first ISSUE cycle.
    assign wdata_src = first_q ? dmem_wdata_delayed : wdata_q;

    always_comb begin
        wstrb_raw     = 4'hF;
        bus_req_wdata = wdata_src;
        case (size_q[1:0])
            2'd0: begin
                wstrb_raw     = 4'b0001 << addr_q[1:0];
                bus_req_wdata = {4{wdata_src[7:0]}};
            end
            2'd1: begin
                wstrb_raw     = 4'b0011 << addr_q[1:0];
                bus_req_wdata = {2{wdata_src[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = bus_resp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = shifted;
        case (size_q[1:0])
            2'd0:    load_ext = {{24{~size_q[2] & shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = {{16{~size_q[2] & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign rdata_cmb     = wen_q ? 32'h0 : load_ext;
    assign dmem_rdata    = complete ? rdata_cmb : rdata_q;
    assign dmem_badmem_e = (state == BAD) || (complete && bus_resp_err) || timeout_hit;
    assign dmem_wait     = ((state == ISSUE) || ((state == WAIT) && !bus_resp_valid)) && !timeout_hit;
    assign bus_req_valid = (state == ISSUE) && !timeout_hit;
    assign bus_req_addr  = {addr_q[31:2], 2'b00};
    assign bus_req_wen   = wen_q;
    assign bus_req_wstrb = wen_q ? wstrb_raw : 4'b0000;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Randomized core/bus stimulus checked against a transaction-level model of the dmem bridge.
module tb_vscale_dmem_bridge;

`ifdef VSCALE_DMEM_BRIDGE_TIMEOUT_EN
    localparam int RD_MAX = 1, RSP_MAX = 1, RD_LONG = 2;
`else
    localparam int RD_MAX = 3, RSP_MAX = 3, RD_LONG = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_en, dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr, dmem_wdata_delayed;
    logic        dmem_wait;
    logic [31:0] dmem_rdata;
    logic        dmem_badmem_e;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_wen;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    vscale_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
        .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata),
        .dmem_badmem_e(dmem_badmem_e), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen), .bus_req_wstrb(bus_req_wstrb),
        .bus_req_wdata(bus_req_wdata), .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [2:0]  size;
        logic [31:0] addr, wd;
        int          rd, rsp;
        logic [31:0] rword;
        logic        err, gap, lit;
        logic [31:0] lit_addr;
        logic [3:0]  lit_strb;
        logic [31:0] lit_wd, lit_rd;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outcome of the transaction whose response lands in the next stall-free cycle.
    int          pend_kind = 0;  // 0 none, 1 bus response, 2 misaligned pulse
    logic [31:0] pend_word, pend_rd, pend_lit_rd;
    logic        pend_err, pend_lit;
    logic [31:0] hold_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] sz, input logic [31:0] a, input logic w);
        int nb;
        int off;
        if (!w) return 4'h0;
        nb  = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
        if (sz[1:0] == 2'd0) return (d % 256) * 32'h01010101;
        if (sz[1:0] == 2'd1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int off;
        off = int'(a % 4);
        v = w >> (8 * off);
        if (sz[1:0] == 2'd0) begin
            v = v % 256;
            if (!sz[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz[1:0] == 2'd1) begin
            v = v % 65536;
            if (!sz[2] && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic txn_t mk(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wd, input int rd, input int rsp,
                                input logic [31:0] rword, input logic err, input logic gap,
                                input logic lit, input logic [31:0] lit_addr, input logic [3:0] lit_strb,
                                input logic [31:0] lit_wd, input logic [31:0] lit_rd);
        txn_t t;
        t.wen = wen; t.size = size; t.addr = addr; t.wd = wd; t.rd = rd; t.rsp = rsp;
        t.rword = rword; t.err = err; t.gap = gap; t.lit = lit;
        t.lit_addr = lit_addr; t.lit_strb = lit_strb; t.lit_wd = lit_wd; t.lit_rd = lit_rd;
        return t;
    endfunction

    task automatic junk_core();
        dmem_en   = 1'($urandom);
        dmem_wen  = 1'($urandom);
        dmem_size = 3'($urandom);
        dmem_addr = $urandom;
    endtask

    // A cycle in which the core is not stalled: completes any pending access, optionally issues t.
    task automatic free_cycle(input logic en, input txn_t t);
        logic exp_bad;
        @(negedge clk);
        if (en) begin
            dmem_en = 1'b1; dmem_wen = t.wen; dmem_size = t.size; dmem_addr = t.addr;
        end else begin
            junk_core();
            dmem_en = 1'b0;
        end
        dmem_wdata_delayed = $urandom;
        bus_req_ready      = 1'($urandom);
        if (pend_kind == 1) begin
            bus_resp_valid = 1'b1; bus_resp_rdata = pend_word; bus_resp_err = pend_err;
        end else begin
            bus_resp_valid = 1'($urandom); bus_resp_rdata = $urandom; bus_resp_err = 1'($urandom);
        end
        #4;
        exp_bad = (pend_kind == 1) ? pend_err : (pend_kind == 2);
        if (pend_kind == 1) hold_rd = pend_rd;
        chk("free_wait", 32'(dmem_wait), 32'h0);
        chk("free_req_valid", 32'(bus_req_valid), 32'h0);
        chk("free_badmem", 32'(dmem_badmem_e), 32'(exp_bad));
        chk("free_rdata", dmem_rdata, hold_rd);
        if (pend_lit) chk("lit_rdata", dmem_rdata, pend_lit_rd);
        pend_kind = 0;
        pend_lit  = 1'b0;
    endtask

    task automatic run_txn(input txn_t t);
        if (t.gap) free_cycle(1'b0, t);
        free_cycle(1'b1, t);
        if (m_misal(t.size[1:0], t.addr)) begin
            pend_kind = 2;
            return;
        end
        for (int k = 0; k <= t.rd; k++) begin
            @(negedge clk);
            junk_core();
            dmem_wdata_delayed = (k == 0) ? t.wd : $urandom;
            bus_req_ready      = (k == t.rd);
            bus_resp_valid     = 1'($urandom);
            bus_resp_rdata     = $urandom;
            bus_resp_err       = 1'($urandom);
            #4;
            chk("issue_valid", 32'(bus_req_valid), 32'h1);
            chk("issue_wait", 32'(dmem_wait), 32'h1);
            chk("issue_badmem", 32'(dmem_badmem_e), 32'h0);
            chk("issue_rdata_hold", dmem_rdata, hold_rd);
            chk("issue_addr", bus_req_addr, t.addr - t.addr % 4);
            chk("issue_wen", 32'(bus_req_wen), 32'(t.wen));
            chk("issue_wstrb", 32'(bus_req_wstrb), 32'(m_strb(t.size, t.addr, t.wen)));
            if (t.wen) chk("issue_wdata", bus_req_wdata, m_wdata(t.size, t.wd));
            if (t.lit && k == 0) begin
                chk("lit_addr", bus_req_addr, t.lit_addr);
                chk("lit_wstrb", 32'(bus_req_wstrb), 32'(t.lit_strb));
                if (t.wen) chk("lit_wdata", bus_req_wdata, t.lit_wd);
            end
        end
        for (int k = 1; k < t.rsp; k++) begin
            @(negedge clk);
            junk_core();
            bus_req_ready  = 1'($urandom);
            bus_resp_valid = 1'b0;
            #4;
            chk("wait_valid", 32'(bus_req_valid), 32'h0);
            chk("wait_wait", 32'(dmem_wait), 32'h1);
            chk("wait_badmem", 32'(dmem_badmem_e), 32'h0);
            chk("wait_rdata_hold", dmem_rdata, hold_rd);
        end
        pend_kind   = 1;
        pend_word   = t.rword;
        pend_err    = t.err;
        pend_rd     = t.wen ? 32'h0 : m_load(t.size, t.addr, t.rword);
        pend_lit    = t.lit;
        pend_lit_rd = t.lit_rd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        t;
        logic [1:0]  s;
        logic [31:0] a;
        reset = 1'b1;
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = 32'h0;
        dmem_wdata_delayed = 32'h0; bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0; bus_resp_rdata = 32'h0; bus_resp_err = 1'b0;
        pend_lit = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        chk("reset_valid", 32'(bus_req_valid), 32'h0);
        chk("reset_wait", 32'(dmem_wait), 32'h0);
        chk("reset_badmem", 32'(dmem_badmem_e), 32'h0);
        chk("reset_rdata", dmem_rdata, 32'h0);
        chk("reset_wstrb", 32'(bus_req_wstrb), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_txn(mk(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'h8899AABB, 1'b0, 1'b1,
                   1'b1, 32'h100, 4'h0, 32'h0, 32'h8899AABB));
        run_txn(mk(1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF0000, 1'b0, 1'b0,
                   1'b1, 32'h100, 4'h0, 32'h0, 32'hFFFFFF80));
        run_txn(mk(1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80FF0000, 1'b0, 1'b1,
                   1'b1, 32'h100, 4'h0, 32'h0, 32'h000080FF));
        run_txn(mk(1'b1, 3'b000, 32'h201, 32'h000000A5, 0, 1, 32'h12345678, 1'b0, 1'b0,
                   1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0));
        run_txn(mk(1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 32'h0, 1'b0, 1'b1,
                   1'b0, 32'h0, 4'h0, 32'h0, 32'h0));
        run_txn(mk(1'b0, 3'b010, 32'h300, 32'h0, RD_LONG, 1, 32'hCAFEF00D, 1'b0, 1'b1,
                   1'b1, 32'h300, 4'h0, 32'h0, 32'hCAFEF00D));
        run_txn(mk(1'b0, 3'b010, 32'h304, 32'h0, 0, 2, 32'h0BADBEEF, 1'b1, 1'b0,
                   1'b1, 32'h304, 4'h0, 32'h0, 32'h0BADBEEF));

        for (int i = 0; i < 200; i++) begin
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                else if (s == 2'd2) a[1:0] = 2'b00;
            end
            t = mk(1'($urandom), {1'($urandom), s}, a, $urandom,
                   $urandom_range(0, RD_MAX), $urandom_range(1, RSP_MAX), $urandom,
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                   1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
            run_txn(t);
        end
        free_cycle(1'b0, t);

        // Reset while the request is on the bus.
        t = mk(1'b0, 3'b010, 32'h400, 32'h0, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        free_cycle(1'b1, t);
        @(negedge clk);
        dmem_en = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1 chk("pre_reset_valid", 32'(bus_req_valid), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(bus_req_valid), 32'h0);
        chk("async_reset_wait", 32'(dmem_wait), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        hold_rd = 32'h0;
        #4 chk("post_reset_rdata", dmem_rdata, 32'h0);

        // Reset while awaiting the response; the late response must be dropped.
        free_cycle(1'b1, t);
        @(negedge clk);
        dmem_en = 1'b0; bus_req_ready = 1'b1;
        #4 chk("issue2_valid", 32'(bus_req_valid), 32'h1);
        @(negedge clk);
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1 chk("wait2_wait", 32'(dmem_wait), 32'h1);
        #1 reset = 1'b1;
        #1 chk("wait_reset_wait", 32'(dmem_wait), 32'h0);
        chk("wait_reset_valid", 32'(bus_req_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hDEADBEEF; bus_resp_err = 1'b1;
        #4;
        chk("late_resp_badmem", 32'(dmem_badmem_e), 32'h0);
        chk("late_resp_rdata", dmem_rdata, 32'h0);
        chk("late_resp_wait", 32'(dmem_wait), 32'h0);
        run_txn(mk(1'b0, 3'b001, 32'h502, 32'h0, 0, 1, 32'h7FFF1234, 1'b0, 1'b1,
                   1'b1, 32'h500, 4'h0, 32'h0, 32'h00007FFF));
        free_cycle(1'b0, t);

`ifdef VSCALE_DMEM_BRIDGE_TIMEOUT_EN
        t = mk(1'b0, 3'b010, 32'h600, 32'h0, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        free_cycle(1'b1, t);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            dmem_en = 1'b0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
            #4;
            chk("to_valid", 32'(bus_req_valid), (k < 4) ? 32'h1 : 32'h0);
            chk("to_wait", 32'(dmem_wait), (k < 4) ? 32'h1 : 32'h0);
            chk("to_badmem", 32'(dmem_badmem_e), (k < 4) ? 32'h0 : 32'h1);
        end
        @(negedge clk);
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h11111111; bus_resp_err = 1'b1;
        #4;
        chk("to_late_badmem", 32'(dmem_badmem_e), 32'h0);
        chk("to_late_rdata", dmem_rdata, hold_rd);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
